pio_blink_out: RTL and testbench
================================

PIO_BLINK_OUT -- requirements
Module: pio_blink_out

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning output port width in bits (legal range 1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0, meaning the DATA register value after reset (WIDTH bits).
REQ-003 SHALL have parameter CNT_W, default 32, meaning blink counter and PERIOD register width (legal range 1..32).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port address, input, 3, register word select.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe; a write occurs only when chipselect=1 and write_n=0.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port readdata, output, 32, combinational read data (zero wait states); unused upper bits are 0.
REQ-011 SHALL have port out_port, output, WIDTH, the driven pin value.

Function
REQ-012 SHALL decode the register map as follows:
- 0 DATA (rw)
- 1 BLINK_EN (rw, WIDTH bits)
- 2 PERIOD (rw, CNT_W bits)
- 3 STATUS (ro; bit0 = phase)
- 4 OUTSET (wo)
- 5 OUTCLEAR (wo)
- 6, 7 reserved
REQ-013 SHALL load DATA with writedata[WIDTH-1:0] on a write to address 0.
REQ-014 SHALL, on a write to address 4, set DATA to DATA | writedata[WIDTH-1:0] in one cycle.
REQ-015 SHALL, on a write to address 5, set DATA to DATA & ~writedata[WIDTH-1:0] in one cycle.
REQ-016 SHALL ignore writes to addresses 3, 6 and 7.
REQ-017 SHALL return 0 on reads of addresses 4-7, and SHALL return 0 on readdata whenever the block is not selected.
REQ-018 SHALL drive out_port[i] = DATA[i] & (BLINK_EN[i] ? phase : 1), registered-source only, with no combinational path from the bus to out_port.
REQ-019 SHALL run the blink counter as follows:
- PERIOD=0: counter held at 0, phase held at 1.
- PERIOD>0: counter increments each cycle; when counter==PERIOD-1, counter wraps to 0 and phase toggles.
REQ-020 SHALL, on a write to PERIOD, load the new value, clear the counter to 0 and set phase to 1 in the same edge; the write takes priority over a coincident wrap.
REQ-021 SHALL leave the counter and phase unaffected by writes to DATA, BLINK_EN, OUTSET and OUTCLEAR.
REQ-022 SHALL make register writes visible on out_port and readdata from the cycle after the write edge (1-cycle latency).
REQ-023 SHALL give PERIOD=1 a phase toggle every cycle (blink half-period = PERIOD clocks, full period = 2*PERIOD).

Reset
REQ-024 SHALL, when reset_n=0 at a rising clk edge, set DATA=RESET_VALUE, BLINK_EN=0, PERIOD=0, counter=0 and phase=1, so that out_port=RESET_VALUE in the following cycle.
REQ-025 SHALL give reset priority over any coincident bus write.
REQ-026 SHALL NOT change any state asynchronously while reset_n=0 between clock edges.
REQ-027 SHALL abort a blink in progress when reset is asserted mid-period; after release, blinking is disabled until software re-enables it.

Verification
REQ-028 SHALL cover reset: hold reset_n=0 for 2 clocks with a write of 0xFF to DATA pending -> out_port=RESET_VALUE and readdata at address 0 equals RESET_VALUE.
REQ-029 SHALL cover set/clear: write DATA=0x0F, OUTSET 0x30, then OUTCLEAR 0x03 -> DATA reads 0x0F, then 0x3F, then 0x3C, each visible one cycle after its write.
REQ-030 SHALL cover blink: DATA=0xFF, BLINK_EN=0x01, PERIOD=4 -> out_port[0] follows 1,1,1,1,0,0,0,0,... (starting after the PERIOD write) while out_port[7:1] stays 0x7F.
REQ-031 SHALL cover the PERIOD write colliding with a wrap: write PERIOD=3 on the cycle where counter==PERIOD-1 -> phase=1, counter=0, and no toggle occurs.
REQ-032 SHALL cover PERIOD=0: with BLINK_EN=0xFF and DATA=0xA5, out_port stays 0xA5 indefinitely and STATUS reads 1.
REQ-033 SHALL cover the reserved and write-only addresses: write 0xDEADBEEF to addresses 3, 6 and 7 -> no register changes, and reads of addresses 4-7 return 0.

Source files
------------

// File: rtl/pio_blink_out.sv
// Memory-mapped output port with per-bit blink gating.
// A shared counter toggles the blink phase every PERIOD clocks.
module pio_blink_out #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
    parameter int unsigned           CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] blink_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;

    logic wr;
    logic wr_data;
    logic wr_blink;
    logic wr_period;
    logic wr_set;
    logic wr_clr;

    assign wr        = chipselect && !write_n;
    assign wr_data   = wr && (address == 3'd0);
    assign wr_blink  = wr && (address == 3'd1);
    assign wr_period = wr && (address == 3'd2);
    assign wr_set    = wr && (address == 3'd4);
    assign wr_clr    = wr && (address == 3'd5);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q  <= RESET_VALUE;
            blink_q <= '0;
        end else begin
            if (wr_data)
                data_q <= writedata[WIDTH-1:0];
            else if (wr_set)
                data_q <= data_q | writedata[WIDTH-1:0];
            else if (wr_clr)
                data_q <= data_q & ~writedata[WIDTH-1:0];
            if (wr_blink)
                blink_q <= writedata[WIDTH-1:0];
        end
    end

    // A PERIOD write restarts the blink cycle and wins over a wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else if (wr_period) begin
            period_q <= writedata[CNT_W-1:0];
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else if (period_q == '0) begin
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else if (cnt_q == period_q - CNT_ONE) begin
            cnt_q    <= '0;
            phase_q  <= ~phase_q;
        end else begin
            cnt_q    <= cnt_q + CNT_ONE;
        end
    end

    assign out_port = data_q & ~(blink_q & {WIDTH{~phase_q}});

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            unique case (address)
                3'd0:    readdata[WIDTH-1:0] = data_q;
                3'd1:    readdata[WIDTH-1:0] = blink_q;
                3'd2:    readdata[CNT_W-1:0] = period_q;
                3'd3:    readdata[0]         = phase_q;
                default: readdata            = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_blink_out.sv
// Directed bench for pio_blink_out: register table plus blink,
// collision, PERIOD=0 and mid-period reset sequences.
module tb_pio_blink_out;

    localparam logic [7:0] RV = 8'h5A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pio_blink_out #(
        .WIDTH(8),
        .RESET_VALUE(RV),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    typedef struct {
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        v          = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] v;
    logic        ph;

    initial begin
        vt[0]  = '{3'd0, 32'h0000_000F, 3'd0, 32'h0F, 8'h0F};
        vt[1]  = '{3'd4, 32'h0000_0030, 3'd0, 32'h3F, 8'h3F};
        vt[2]  = '{3'd5, 32'h0000_0003, 3'd0, 32'h3C, 8'h3C};
        vt[3]  = '{3'd0, 32'h0000_01A5, 3'd0, 32'hA5, 8'hA5};
        vt[4]  = '{3'd3, 32'hDEAD_BEEF, 3'd0, 32'hA5, 8'hA5};
        vt[5]  = '{3'd6, 32'hDEAD_BEEF, 3'd6, 32'h00, 8'hA5};
        vt[6]  = '{3'd7, 32'hDEAD_BEEF, 3'd7, 32'h00, 8'hA5};
        vt[7]  = '{3'd1, 32'h0000_00FF, 3'd1, 32'hFF, 8'hA5};
        vt[8]  = '{3'd4, 32'h0000_0000, 3'd4, 32'h00, 8'hA5};
        vt[9]  = '{3'd5, 32'h0000_0000, 3'd5, 32'h00, 8'hA5};
        vt[10] = '{3'd2, 32'h0000_0000, 3'd3, 32'h01, 8'hA5};
        vt[11] = '{3'd1, 32'h0000_01FF, 3'd1, 32'hFF, 8'hA5};

        // Reset held 2 clocks with a DATA write pending.
        reset_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'hFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_port", {24'h0, out_port}, {24'h0, RV});
        chk("reset readdata", readdata, {24'h0, RV});
        reset_n    = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(3'd1, v); chk("reset blink_en", v, 32'h0);
        rd(3'd2, v); chk("reset period", v, 32'h0);
        rd(3'd3, v); chk("reset status", v, 32'h1);
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            wr(vt[i].waddr, vt[i].wdata);
            rd(vt[i].raddr, v);
            chk($sformatf("vec%0d rd", i), v, vt[i].exp_rd);
            chk($sformatf("vec%0d out", i), {24'h0, out_port},
                {24'h0, vt[i].exp_out});
            @(negedge clk);
        end

        address    = 3'd0;
        chipselect = 1'b0;
        #1;
        chk("unselected readdata", readdata, 32'h0);

        // PERIOD=0 with all bits blink-enabled: no blinking at all.
        for (int k = 0; k < 20; k++) begin
            chk("p0 out", {24'h0, out_port}, 32'hA5);
            rd(3'd3, v); chk("p0 status", v, 32'h1);
            @(negedge clk);
        end

        // Blink bit 0 with PERIOD=4.
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h4);
        for (int k = 0; k < 19; k++) begin
            ph = ((k / 4) % 2) == 0;
            chk($sformatf("blink out k%0d", k), {24'h0, out_port},
                {24'h0, 7'h7F, ph});
            rd(3'd3, v);
            chk($sformatf("blink status k%0d", k), v, {31'h0, ph});
            @(negedge clk);
        end

        // Counter is 3 (==PERIOD-1) with phase 1: write lands on a wrap.
        wr(3'd2, 32'h3);
        rd(3'd3, v); chk("collide status", v, 32'h1);
        rd(3'd2, v); chk("collide period", v, 32'h3);
        for (int k = 0; k < 9; k++) begin
            ph = ((k / 3) % 2) == 0;
            chk($sformatf("p3 out k%0d", k), {24'h0, out_port},
                {24'h0, 7'h7F, ph});
            @(negedge clk);
        end

        // Mid-period reset: blink at phase 0, then reset.
        wr(3'd2, 32'h4);
        repeat (4) @(negedge clk);
        chk("pre-reset out", {24'h0, out_port}, 32'hFE);
        reset_n = 1'b0;
        #1;
        chk("no async reset", {24'h0, out_port}, 32'hFE);
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid reset out", {24'h0, out_port}, {24'h0, RV});
        rd(3'd1, v); chk("mid reset blink_en", v, 32'h0);
        rd(3'd2, v); chk("mid reset period", v, 32'h0);
        rd(3'd3, v); chk("mid reset status", v, 32'h1);
        @(negedge clk);
        wr(3'd0, 32'hFF);
        repeat (6) @(negedge clk);
        chk("post reset no blink", {24'h0, out_port}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
